// File: rtl/ntt_pkg.sv
// ntt_pkg: default NTT field constants and the shared modular add/sub helper.
package ntt_pkg;
  localparam int unsigned DEF_LOGQ = 17;
  localparam int unsigned DEF_Q = 65537;
  localparam int unsigned DEF_W4 = 256;
  localparam int unsigned DEF_INV4 = 49153;
  localparam int unsigned DEF_TAGW = 8;
  // Operands must already lie in [0,q); the result does too.
  function automatic logic [31:0] mod_addsub(input logic [31:0] x, input logic [31:0] y, input logic [31:0] q, input logic sub);
    logic [31:0] s;
    s = sub ? x + (x >= y ? 32'd0 : q) - y : x + y;
    return (!sub && s >= q) ? s - q : s;
  endfunction
endpackage

// File: rtl/radix_4_ntt_pipe_if.sv
// radix_4_ntt_pipe_if: beat-in / beat-out handshake bundle for the radix-4 NTT pipe.
interface radix_4_ntt_pipe_if #(
  parameter int unsigned LOGQ = 17,
  parameter int unsigned TAGW = 8
);
  logic in_valid, in_ready, inv, scale, out_valid, out_ready;
  logic [LOGQ-1:0] a0, a1, a2, a3, tf0, tf1, tf2, tf3, A0, A1, A2, A3;
  logic [TAGW-1:0] in_tag, out_tag;
  modport master (
    output in_valid, a0, a1, a2, a3, tf0, tf1, tf2, tf3, inv, scale, in_tag, out_ready,
    input in_ready, out_valid, A0, A1, A2, A3, out_tag
  );
  modport slave (
    input in_valid, a0, a1, a2, a3, tf0, tf1, tf2, tf3, inv, scale, in_tag, out_ready,
    output in_ready, out_valid, A0, A1, A2, A3, out_tag
  );
endinterface

// File: rtl/ntt_modmul.sv
// ntt_modmul: combinational LOGQ x LOGQ multiply, fully reduced mod Q.
module ntt_modmul #(
  parameter int unsigned LOGQ = 17,
  parameter int unsigned Q = 65537
) (
  input  logic [LOGQ-1:0] x,
  input  logic [LOGQ-1:0] y,
  output logic [LOGQ-1:0] p
);
  localparam logic [2*LOGQ-1:0] QW = (2*LOGQ)'(Q);
  logic [2*LOGQ-1:0] full;
  assign full = x * y;
  assign p = LOGQ'(full % QW);
endmodule

// File: rtl/radix_4_ntt_pipe.sv
// radix_4_ntt_pipe: 4-stage radix-4 NTT butterfly with bit-reversed twiddled outputs,
// optional 1/4 scaling and a single global stall.
module radix_4_ntt_pipe
  import ntt_pkg::*;
#(
  parameter int unsigned LOGQ = DEF_LOGQ,
  parameter int unsigned Q = DEF_Q,
  parameter int unsigned W4 = DEF_W4,
  parameter int unsigned INV4 = DEF_INV4,
  parameter int unsigned TAGW = DEF_TAGW
) (
  input logic clk,
  input logic rst,
  radix_4_ntt_pipe_if.slave bus
);
  typedef logic [3:0][LOGQ-1:0] vec_t;
  function automatic logic [LOGQ-1:0] md(input logic [LOGQ-1:0] x, input logic [LOGQ-1:0] y, input logic sub);
    return LOGQ'(mod_addsub(32'(x), 32'(y), 32'(Q), sub));
  endfunction
  logic adv;
  vec_t a_in, tf_in;
  assign adv = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  assign a_in = {bus.a3, bus.a2, bus.a1, bus.a0};
  assign tf_in = {bus.tf3, bus.tf2, bus.tf1, bus.tf0};
  // S1 holds {a1-a3, a1+a3, a0-a2, a0+a2} from index 3 down to 0
  logic v1, inv1, sc1;
  vec_t t1, tf1;
  logic [TAGW-1:0] tag1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1 <= 1'b0;
      inv1 <= 1'b0;
      sc1 <= 1'b0;
      t1 <= '0;
      tf1 <= '0;
      tag1 <= '0;
    end else if (adv) begin
      v1 <= bus.in_valid;
      inv1 <= bus.inv;
      sc1 <= bus.scale;
      t1 <= {md(a_in[1], a_in[3], 1'b1), md(a_in[1], a_in[3], 1'b0),
             md(a_in[0], a_in[2], 1'b1), md(a_in[0], a_in[2], 1'b0)};
      tf1 <= tf_in;
      tag1 <= bus.in_tag;
    end
  // S2 stores results already in bit-reversed order: X0, X2, X1, X3
  logic [LOGQ-1:0] wd;
  ntt_modmul #(.LOGQ(LOGQ), .Q(Q)) u_wmul (
    .x(t1[3]), .y(inv1 ? LOGQ'(Q - W4) : LOGQ'(W4)), .p(wd)
  );
  logic v2, sc2;
  vec_t y2, tf2;
  logic [TAGW-1:0] tag2;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v2 <= 1'b0;
      sc2 <= 1'b0;
      y2 <= '0;
      tf2 <= '0;
      tag2 <= '0;
    end else if (adv) begin
      v2 <= v1;
      sc2 <= sc1;
      y2 <= {md(t1[1], wd, 1'b1), md(t1[1], wd, 1'b0),
             md(t1[0], t1[2], 1'b1), md(t1[0], t1[2], 1'b0)};
      tf2 <= tf1;
      tag2 <= tag1;
    end
  logic [LOGQ-1:0] z3n [4];
  logic [LOGQ-1:0] zs [4];
  logic v3, sc3;
  vec_t z3;
  logic [TAGW-1:0] tag3;
  for (genvar i = 0; i < 4; i++) begin : g_mul
    ntt_modmul #(.LOGQ(LOGQ), .Q(Q)) u_tfmul (.x(y2[i]), .y(tf2[i]), .p(z3n[i]));
    ntt_modmul #(.LOGQ(LOGQ), .Q(Q)) u_scmul (.x(z3[i]), .y(LOGQ'(INV4)), .p(zs[i]));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v3 <= 1'b0;
      sc3 <= 1'b0;
      z3 <= '0;
      tag3 <= '0;
    end else if (adv) begin
      v3 <= v2;
      sc3 <= sc2;
      z3 <= {z3n[3], z3n[2], z3n[1], z3n[0]};
      tag3 <= tag2;
    end
  // Output registers only load on valid slots so bubbles leave the last result visible
  logic v4;
  vec_t a4;
  logic [TAGW-1:0] tag4;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v4 <= 1'b0;
      a4 <= '0;
      tag4 <= '0;
    end else if (adv) begin
      v4 <= v3;
      if (v3) begin
        a4 <= sc3 ? {zs[3], zs[2], zs[1], zs[0]} : z3;
        tag4 <= tag3;
      end
    end
  assign bus.out_valid = v4;
  assign bus.out_tag = tag4;
  assign bus.A0 = a4[0];
  assign bus.A1 = a4[1];
  assign bus.A2 = a4[2];
  assign bus.A3 = a4[3];
endmodule

// File: tb/tb_radix_4_ntt_pipe.sv
// tb_radix_4_ntt_pipe: directed and randomized checks of radix_4_ntt_pipe against a
// DFT-definition model (X_k = sum a_j w^(jk)) with an in-order scoreboard.
module tb_radix_4_ntt_pipe;
  localparam int unsigned Q = 65537;
  localparam int unsigned W4 = 256;
  localparam int unsigned INV4 = 49153;
  typedef logic [3:0][16:0] vec_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [75:0] exp_q [$];
  always #5 clk = ~clk;
  radix_4_ntt_pipe_if #(.LOGQ(17), .TAGW(8)) bus ();
  radix_4_ntt_pipe dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [75:0] model(input vec_t a, input vec_t tf, input logic inv, input logic sc, input logic [7:0] tag);
    longint w, p;
    longint x [4];
    longint y [4];
    w = inv ? longint'(Q - W4) : longint'(W4);
    for (int k = 0; k < 4; k++) begin
      x[k] = 0;
      for (int j = 0; j < 4; j++) begin
        p = 1;
        for (int e = 0; e < j * k; e++) p = p * w % Q;
        x[k] = (x[k] + longint'(a[j]) * p) % Q;
      end
    end
    y[0] = x[0] * longint'(tf[0]) % Q;
    y[1] = x[2] * longint'(tf[1]) % Q;
    y[2] = x[1] * longint'(tf[2]) % Q;
    y[3] = x[3] * longint'(tf[3]) % Q;
    if (sc) for (int i = 0; i < 4; i++) y[i] = y[i] * INV4 % Q;
    return {17'(y[3]), 17'(y[2]), 17'(y[1]), 17'(y[0]), tag};
  endfunction
  function automatic logic [16:0] rv();
    int unsigned r;
    r = $urandom_range(0, 7);
    return r == 0 ? 17'(Q - 1) : r == 1 ? 17'd0 : 17'($urandom_range(0, Q - 1));
  endfunction
  function automatic vec_t rvec();
    vec_t r;
    for (int i = 0; i < 4; i++) r[i] = rv();
    return r;
  endfunction
  function automatic logic [75:0] got();
    return {bus.A3, bus.A2, bus.A1, bus.A0, bus.out_tag};
  endfunction
  task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, expv);
    end
  endtask
  task automatic cycle(input logic iv, input vec_t a, input vec_t tf, input logic inv, input logic sc, input logic [7:0] tag, input logic ordy);
    logic [75:0] g;
    logic held;
    bus.in_valid = iv;
    {bus.a3, bus.a2, bus.a1, bus.a0} = a;
    {bus.tf3, bus.tf2, bus.tf1, bus.tf0} = tf;
    bus.inv = inv;
    bus.scale = sc;
    bus.in_tag = tag;
    bus.out_ready = ordy;
    #1;
    g = got();
    chk("in_ready", 128'(bus.in_ready), 128'(!bus.out_valid || ordy));
    if (iv && bus.in_ready) exp_q.push_back(model(a, tf, inv, sc, tag));
    if (bus.out_valid && ordy) begin
      chk("beat_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) chk("beat", 128'(g), 128'(exp_q.pop_front()));
    end
    held = bus.out_valid && !ordy;
    @(posedge clk);
    @(negedge clk);
    if (held) chk("stall_hold", {bus.out_valid, got()}, {1'b1, g});
  endtask
  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 8'd0, 1'b1);
  endtask
  task automatic directed(input string nm, input vec_t a, input vec_t tf, input logic inv, input logic sc, input logic [7:0] tag, input logic [67:0] expa);
    logic [75:0] g;
    cycle(1'b1, a, tf, inv, sc, tag, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk({nm, "_early"}, 128'(bus.out_valid), 128'(0));
      idle();
    end
    chk({nm, "_valid"}, {bus.out_valid, bus.out_tag}, {1'b1, tag});
    g = got();
    chk(nm, 128'(g[75:8]), 128'(expa));
    idle();
    chk({nm, "_bubble_hold"}, {bus.out_valid, got()}, {1'b0, g});
  endtask
  task automatic stream(input int n);
    int sent = 0;
    int cyc = 0;
    logic iv, ordy, acc;
    while (sent < n && cyc < 4000) begin
      iv = $urandom_range(0, 3) != 0;
      ordy = $urandom_range(0, 2) != 0;
      acc = iv && (!bus.out_valid || ordy);
      cycle(iv, rvec(), rvec(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), ordy);
      sent += int'(acc);
      cyc++;
    end
    chk("stream_sent", 128'(sent), 128'(n));
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) idle();
    chk("stream_drained", 128'(exp_q.size()), 128'(0));
  endtask
  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    {bus.a3, bus.a2, bus.a1, bus.a0} = '0;
    {bus.tf3, bus.tf2, bus.tf1, bus.tf0} = '0;
    bus.inv = 1'b0;
    bus.scale = 1'b0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_out", {bus.out_valid, got()}, '0);
    chk("reset_in_ready", 128'(bus.in_ready), 128'(1));
    rst = 1'b0;
    directed("impulse", {17'd0, 17'd0, 17'd0, 17'd1}, {4{17'd1}}, 1'b0, 1'b0, 8'h11,
             {17'd1, 17'd1, 17'd1, 17'd1});
    directed("a1_fwd", {17'd0, 17'd0, 17'd1, 17'd0}, {4{17'd1}}, 1'b0, 1'b0, 8'h12,
             {17'd65281, 17'd256, 17'd65536, 17'd1});
    directed("a1_inv", {17'd0, 17'd0, 17'd1, 17'd0}, {4{17'd1}}, 1'b1, 1'b0, 8'h13,
             {17'd256, 17'd65281, 17'd65536, 17'd1});
    directed("ones_inv_scaled", {4{17'd1}}, {4{17'd1}}, 1'b1, 1'b1, 8'h14,
             {17'd0, 17'd0, 17'd0, 17'd1});
    directed("max_tf2", {4{17'd65536}}, {4{17'd2}}, 1'b0, 1'b0, 8'h15,
             {17'd0, 17'd0, 17'd0, 17'd65529});
    stream(100);
    for (int i = 0; i < 3; i++) cycle(1'b1, rvec(), rvec(), 1'b0, 1'b0, 8'(8'hA0 + i), 1'b1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midreset_out", {bus.out_valid, got()}, '0);
    chk("midreset_in_ready", 128'(bus.in_ready), 128'(1));
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midreset_held", {bus.out_valid, got()}, '0);
    rst = 1'b0;
    directed("after_reset", {17'd0, 17'd0, 17'd0, 17'd1}, {4{17'd1}}, 1'b0, 1'b0, 8'h55,
             {17'd1, 17'd1, 17'd1, 17'd1});
    stream(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
